// File: rtl/rd_adr_sequencer.sv
// -----------------------------------------------------------------------------
// rd_adr_sequencer
//
// N-channel read-address sequencer. Each channel raises a strobe when its frame
// buffer is ready. A single shared engine serves one channel at a time. For each
// word it emits a timed RD pulse on the granted channel and holds the word
// address stable on the shared address bus. When all words have been read, a
// one-cycle done pulse (write-reset) goes back to the served channel.
//
// Build option:
//   RR_ARB_EN  defined   -> round-robin arbitration starting after the last grant
//              undefined -> fixed priority, lowest channel index wins
//
// Ports:
//   clk      clock
//   rst      asynchronous active-low reset
//   strobe   per-channel request level, asynchronous to clk
//   rd       one-hot RD pulse on the granted channel
//   rd_adr   current word address, 0 when not busy
//   adr_vld  rd_adr valid (identical to busy)
//   cur_ch   granted channel index, 0 when idle
//   busy     engine is serving a channel
//   done     one-cycle pulse on the channel whose transfer finished
// -----------------------------------------------------------------------------
module rd_adr_sequencer #(
  parameter int N_CH     = 5,
  parameter int N_WORDS  = 18,
  parameter int AW       = 5,
  parameter int SLOT_LEN = 64,
  parameter int RD_START = 40,
  parameter int RD_LEN   = 4,
  parameter int CHW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] strobe,
  output logic [N_CH-1:0] rd,
  output logic [AW-1:0]   rd_adr,
  output logic            adr_vld,
  output logic [CHW-1:0]  cur_ch,
  output logic            busy,
  output logic [N_CH-1:0] done
);

  localparam int SW = $clog2(SLOT_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SLOT,
    S_NEXT,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [AW-1:0]   word_q, word_d;
  logic [CHW-1:0]  cur_ch_q, cur_ch_d;
  logic            busy_q, busy_d;
  logic [N_CH-1:0] done_q, done_d;
  logic [N_CH-1:0] armed_q, armed_d;
  logic [N_CH-1:0] sync1_q, s_str_q;

  logic [N_CH-1:0] req;
  logic [N_CH-1:0] cur_oh;
  logic [CHW-1:0]  win;
  logic            win_vld;
  logic            rd_win;

`ifdef RR_ARB_EN
  logic [CHW-1:0]  last_q, last_d;
`endif

  // Two-flop synchroniser for the asynchronous strobe levels.
  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // registers sample pre-edge values and simulation matches the hardware.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      s_str_q <= '0;
    end else begin
      sync1_q <= strobe;
      s_str_q <= sync1_q;
    end
  end

  // A channel requests only while armed; arming waits for the strobe to go
  // low so a strobe held high after done cannot start a second transfer.
  assign req = s_str_q & armed_q;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cur_oh[i] = (cur_ch_q == CHW'(i));
    end
  end

`ifdef RR_ARB_EN
  // Round-robin: lowest requester above the last grant, otherwise wrap to
  // the lowest requester overall.
  always_comb begin
    logic [CHW-1:0] lo;
    logic [CHW-1:0] hi;
    logic           lo_vld;
    logic           hi_vld;
    lo     = '0;
    hi     = '0;
    lo_vld = 1'b0;
    hi_vld = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo     = CHW'(i);
        lo_vld = 1'b1;
        if (CHW'(i) > last_q) begin
          hi     = CHW'(i);
          hi_vld = 1'b1;
        end
      end
    end
    win     = hi_vld ? hi : lo;
    win_vld = lo_vld;
  end
`else
  // Fixed priority: scanning downwards leaves the lowest requester in win.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        win     = CHW'(i);
        win_vld = 1'b1;
      end
    end
  end
`endif

  // RD is high for RD_LEN cycles, from the cycle after slot==RD_START up to
  // and including slot==RD_START+RD_LEN.
  assign rd_win = (state_q == S_SLOT) &&
                  (slot_q >  SW'(RD_START)) &&
                  (slot_q <= SW'(RD_START + RD_LEN));

  always_comb begin
    // NOTE: every signal written here gets its default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d  = state_q;
    slot_d   = slot_q;
    word_d   = word_q;
    cur_ch_d = cur_ch_q;
    busy_d   = busy_q;
    done_d   = '0;
    armed_d  = armed_q;
`ifdef RR_ARB_EN
    last_d   = last_q;
`endif

    for (int i = 0; i < N_CH; i++) begin
      if (!s_str_q[i]) armed_d[i] = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          cur_ch_d = win;
          busy_d   = 1'b1;
          slot_d   = '0;
          word_d   = '0;
          state_d  = S_SLOT;
`ifdef RR_ARB_EN
          last_d   = win;
`endif
        end
      end
      S_SLOT: begin
        if (slot_q == SW'(SLOT_LEN - 1)) begin
          slot_d  = '0;
          state_d = S_NEXT;
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      S_NEXT: begin
        // The address only moves here, where RD is guaranteed low.
        if (word_q == AW'(N_WORDS - 1)) begin
          word_d  = '0;
          busy_d  = 1'b0;
          done_d  = cur_oh;
          armed_d = armed_d & ~cur_oh;
          state_d = S_DONE;
        end else begin
          word_d  = word_q + AW'(1);
          state_d = S_SLOT;
        end
      end
      S_DONE: begin
        // One guard cycle without arbitration between transfers.
        cur_ch_d = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      slot_q   <= '0;
      word_q   <= '0;
      cur_ch_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= '0;
      // NOTE: armed resets to all ones, not zero, so a strobe already high
      // when reset is released is served.
      armed_q  <= '1;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      word_q   <= word_d;
      cur_ch_q <= cur_ch_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      armed_q  <= armed_d;
    end
  end

`ifdef RR_ARB_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= CHW'(N_CH - 1);
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign rd      = rd_win ? cur_oh : '0;
  assign rd_adr  = word_q;
  assign adr_vld = busy_q;
  assign busy    = busy_q;
  assign cur_ch  = cur_ch_q;
  assign done    = done_q;

endmodule

// File: tb/tb_rd_adr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rd_adr_sequencer
//
// Self-checking bench for rd_adr_sequencer. A reference model tracks each
// transfer as "cycles elapsed since grant" and derives the expected address,
// RD window and done pulse arithmetically; arbitration is modelled as a search
// over request flags. Directed scenarios are followed by randomized strobe
// patterns; every cycle compares all outputs with the model.
// -----------------------------------------------------------------------------
module tb_rd_adr_sequencer;

  localparam int N_CH     = 5;
  localparam int N_WORDS  = 18;
  localparam int AW       = 5;
  localparam int SLOT_LEN = 64;
  localparam int RD_START = 40;
  localparam int RD_LEN   = 4;
  localparam int CHW      = 3;
  localparam int WORD_CYC = SLOT_LEN + 1;
  localparam int XFER     = N_WORDS * WORD_CYC;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] strobe;
  logic [N_CH-1:0] rd;
  logic [AW-1:0]   rd_adr;
  logic            adr_vld;
  logic [CHW-1:0]  cur_ch;
  logic            busy;
  logic [N_CH-1:0] done;

  rd_adr_sequencer #(
    .N_CH(N_CH), .N_WORDS(N_WORDS), .AW(AW), .SLOT_LEN(SLOT_LEN),
    .RD_START(RD_START), .RD_LEN(RD_LEN), .CHW(CHW)
  ) dut (
    .clk(clk), .rst(rst), .strobe(strobe), .rd(rd), .rd_adr(rd_adr),
    .adr_vld(adr_vld), .cur_ch(cur_ch), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [N_CH-1:0] m_sh1, m_sstr, m_armed;
  bit              m_active, m_guard, m_done_ev;
  int              m_t, m_ch, m_last;

  task automatic model_init();
    m_sh1     = '0;
    m_sstr    = '0;
    m_armed   = '1;
    m_active  = 0;
    m_guard   = 0;
    m_done_ev = 0;
    m_t       = 0;
    m_ch      = 0;
    m_last    = N_CH - 1;
  endtask

  function automatic int pick(input logic [N_CH-1:0] r);
`ifdef RR_ARB_EN
    for (int k = 0; k < N_CH; k++) begin
      int idx;
      idx = (m_last + 1 + k) % N_CH;
      if (r[idx]) return idx;
    end
`else
    for (int k = 0; k < N_CH; k++) begin
      if (r[k]) return k;
    end
`endif
    return 0;
  endfunction

  // One clock edge of the model; uses pre-edge values throughout.
  task automatic model_step();
    logic [N_CH-1:0] r;
    if (!rst) begin
      model_init();
      return;
    end
    r = m_sstr & m_armed;
    m_done_ev = 0;
    if (m_active) begin
      m_t++;
      if (m_t == XFER) begin
        m_active  = 0;
        m_guard   = 1;
        m_done_ev = 1;
      end
    end else if (m_guard) begin
      m_guard = 0;
      m_ch    = 0;
    end else if (r != '0) begin
      m_ch     = pick(r);
      m_last   = m_ch;
      m_active = 1;
      m_t      = 0;
    end
    for (int i = 0; i < N_CH; i++) begin
      if (!m_sstr[i]) m_armed[i] = 1'b1;
    end
    if (m_done_ev) m_armed[m_ch] = 1'b0;
    m_sstr = m_sh1;
    m_sh1  = strobe;
  endtask

  // ---------------- bookkeeping ----------------
  int              cyc = 0;
  int              grant_cyc = 0;
  int              xfer_len = 0;
  int              done_cnt[N_CH];
  int              rd_rise[N_CH];
  int              rd_hi[N_CH];
  int              dut_grants[$];
  logic            prev_busy = 1'b0;
  logic [N_CH-1:0] prev_rd = '0;

  task automatic clear_stats();
    for (int i = 0; i < N_CH; i++) begin
      done_cnt[i] = 0;
      rd_rise[i]  = 0;
      rd_hi[i]    = 0;
    end
    dut_grants.delete();
  endtask

  task automatic tick();
    logic [N_CH-1:0] oh, e_rd, e_done;
    int              s;
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    oh = '0;
    oh[m_ch] = 1'b1;
    s = m_t % WORD_CYC;
    e_rd   = (m_active && s > RD_START && s <= RD_START + RD_LEN) ? oh : '0;
    e_done = m_done_ev ? oh : '0;
    check("rd",      32'(rd),      32'(e_rd));
    check("rd_adr",  32'(rd_adr),  m_active ? 32'(m_t / WORD_CYC) : 32'd0);
    check("busy",    32'(busy),    32'(m_active));
    check("adr_vld", 32'(adr_vld), 32'(m_active));
    check("done",    32'(done),    32'(e_done));
    check("cur_ch",  32'(cur_ch),  (m_active || m_guard) ? 32'(m_ch) : 32'd0);
    if (busy && !prev_busy) begin
      dut_grants.push_back(int'(cur_ch));
      grant_cyc = cyc;
    end
    for (int i = 0; i < N_CH; i++) begin
      if (done[i]) begin
        done_cnt[i]++;
        xfer_len = cyc - grant_cyc;
      end
      if (rd[i] && !prev_rd[i]) rd_rise[i]++;
      if (rd[i]) rd_hi[i]++;
    end
    prev_busy = busy;
    prev_rd   = rd;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic do_reset();
    rst = 1'b0;
    model_init();
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd",   32'(rd),   32'd0);
    check("rst_adr",  32'(rd_adr), 32'd0);
    check("rst_cur",  32'(cur_ch), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    run(2);
    rst = 1'b1;
  endtask

  task automatic wait_adr(input string tag, input int target, input int limit);
    int n;
    n = 0;
    while (!(busy && int'(rd_adr) == target) && n < limit) begin
      tick();
      n++;
    end
    check(tag, 32'(busy && int'(rd_adr) == target), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    rst    = 1'b0;
    strobe = '0;
    model_init();
    clear_stats();
    run(3);
    rst = 1'b1;
    run(4);

    // T1: single held strobe on ch2.
    strobe = 5'b00100;
    lat = 0;
    while (!busy && lat < 10) begin
      tick();
      lat++;
    end
    check("t1_latency", 32'(lat), 32'd3);
    run(XFER + 300);
    check("t1_done_cnt", 32'(done_cnt[2]), 32'd1);
    check("t1_xfer_len", 32'(xfer_len), 32'(XFER));
    check("t1_rd_pulses", 32'(rd_rise[2]), 32'(N_WORDS));
    check("t1_rd_cycles", 32'(rd_hi[2]), 32'(N_WORDS * RD_LEN));

    // T2: drop for 3 cycles, raise again -> second transfer.
    clear_stats();
    strobe = '0;
    run(3);
    strobe = 5'b00100;
    run(XFER + 20);
    check("t2_done_cnt", 32'(done_cnt[2]), 32'd1);

    // T3: ch0 and ch3 rise together after reset.
    strobe = '0;
    run(4);
    do_reset();
    clear_stats();
    strobe = 5'b01001;
    run(2 * (XFER + 2) + 20);
    check("t3_n_grants", 32'(dut_grants.size()), 32'd2);
    if (dut_grants.size() == 2) begin
      check("t3_first", 32'(dut_grants[0]), 32'd0);
      check("t3_second", 32'(dut_grants[1]), 32'd3);
    end

    // T4: all strobes held -> ascending order, one done each.
    strobe = '0;
    run(4);
    do_reset();
    clear_stats();
    strobe = '1;
    run(N_CH * (XFER + 2) + 200);
    check("t4_n_grants", 32'(dut_grants.size()), 32'(N_CH));
    for (int i = 0; i < N_CH && i < dut_grants.size(); i++) begin
      check($sformatf("t4_order%0d", i), 32'(dut_grants[i]), 32'(i));
      check($sformatf("t4_done%0d", i), 32'(done_cnt[i]), 32'd1);
    end

    // T5: reset during word 7 of ch1; re-run from word 0 afterwards.
    strobe = '0;
    run(4);
    clear_stats();
    strobe = 5'b00010;
    wait_adr("t5_reach_w7", 7, 10 + 8 * WORD_CYC);
    run(20);
    do_reset();
    check("t5_no_done", 32'(done_cnt[1]), 32'd0);
    clear_stats();
    run(XFER + 20);
    check("t5_rerun_done", 32'(done_cnt[1]), 32'd1);
    check("t5_rerun_pulses", 32'(rd_rise[1]), 32'(N_WORDS));

    // T6: strobe[4] dropped during word 3 -> transfer still completes.
    strobe = '0;
    run(4);
    clear_stats();
    strobe = 5'b10000;
    wait_adr("t6_reach_w3", 3, 10 + 4 * WORD_CYC);
    strobe = '0;
    run(XFER);
    check("t6_done", 32'(done_cnt[4]), 32'd1);
    check("t6_pulses", 32'(rd_rise[4]), 32'(N_WORDS));

    // Randomized strobe patterns, short glitches and long holds mixed.
    for (int r = 0; r < 30; r++) begin
      strobe = N_CH'($urandom_range(0, (1 << N_CH) - 1));
      if ($urandom_range(0, 3) == 0) run($urandom_range(1, 8));
      else run($urandom_range(100, 1500));
      if (r == 15) do_reset();
    end
    strobe = '0;
    run(XFER + 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
